// File: rtl/dmem_responder.sv
// Data-memory target behind a valid/ready request port with programmable wait states.
// One access is in flight at a time; the read or byte-masked write commits on the edge entering RESP.
module dmem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic          c_we;
  logic [31:0]   c_addr, c_wdata;
  logic [3:0]    c_be;
  logic [AW-1:0] c_idx;
  logic          c_err;
  logic          commit;

  // With no wait states the commit happens on the accept edge, so use the live request.
  always_comb begin
    c_we    = we_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    c_be    = be_q;
    if (state_q == StIdle) begin
      c_we    = req_we;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_be    = req_be;
    end
  end

  assign c_idx = c_addr[AW+1:2];
  assign c_err = (c_addr[1:0] != 2'b00) || (c_addr[31:2] >= 30'(DEPTH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = StResp;
            commit  = 1'b1;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (commit) begin
      err_d   = c_err;
      rdata_d = (c_err || c_we) ? '0 : mem[c_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == StIdle && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
    end
  end

  // Array is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (commit && c_we && !c_err) begin
      for (int i = 0; i < 4; i++) begin
        if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: unit 0 has two wait states, unit 1 has none.
// Stimulus pushes expected responses; a negedge monitor pops them on each response handshake.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic [1:0]  rv, rr, vv, ee;
  logic        req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_ready;
  logic [31:0] rd0, rd1;

  logic [32:0] sb0[$];
  logic [32:0] sb1[$];
  int n_checks;
  int n_fail;

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(rv[0]), .req_ready(rr[0]), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(vv[0]), .resp_ready(resp_ready), .resp_rdata(rd0), .resp_err(ee[0])
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(rv[1]), .req_ready(rr[1]), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(vv[1]), .resp_ready(resp_ready), .resp_rdata(rd1), .resp_err(ee[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (vv[0] && resp_ready) begin
      if (sb0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp0: got rdata %08h with no expected entry", rd0);
      end else begin
        e = sb0.pop_front();
        chk("rdata0", rd0, e[31:0]);
        chk("err0", {31'b0, ee[0]}, {31'b0, e[32]});
      end
    end
    if (vv[1] && resp_ready) begin
      if (sb1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp1: got rdata %08h with no expected entry", rd1);
      end else begin
        e = sb1.pop_front();
        chk("rdata1", rd1, e[31:0]);
        chk("err1", {31'b0, ee[1]}, {31'b0, e[32]});
      end
    end
  end

  // Full transaction on unit u with resp_ready held high; resp_valid is sampled at edge N+W+1.
  task automatic issue(input int u, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rd, input logic exp_err);
    int n;
    if (u == 0) sb0.push_back({exp_err, exp_rd});
    else sb1.push_back({exp_err, exp_rd});
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    rv[u]     = 1'b1;
    n = 0;
    while (!rr[u] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_before_accept", {31'b0, rr[u]}, 32'd1);
    @(posedge clk); #1;
    rv[u] = 1'b0;
    n = 0;
    while (!vv[u] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("resp_latency", 32'(n + 1), (u == 0) ? 32'd3 : 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b0;
    rv         = 2'b00;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_req_ready", {31'b0, rr[0]}, 32'd1);
    chk("reset_resp_valid", {31'b0, vv[0]}, 32'd0);
    chk("reset_rdata", rd0, 32'd0);
    chk("reset_err", {31'b0, ee[0]}, 32'd0);

    issue(0, 1'b1, 32'h00, 32'h0000_0037, 4'b1111, 32'h0, 1'b0);
    issue(0, 1'b0, 32'h00, 32'h0, 4'b0000, 32'h0000_0037, 1'b0);
    issue(0, 1'b1, 32'h04, 32'hAABB_CCDD, 4'b1111, 32'h0, 1'b0);
    issue(0, 1'b1, 32'h04, 32'h1122_3344, 4'b0101, 32'h0, 1'b0);
    issue(0, 1'b0, 32'h04, 32'h0, 4'b1111, 32'hAA22_CC44, 1'b0);
    issue(0, 1'b0, 32'h02, 32'h0, 4'b1111, 32'h0, 1'b1);
    issue(0, 1'b1, 32'd256, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1);
    issue(0, 1'b0, 32'h00, 32'h0, 4'b1111, 32'h0000_0037, 1'b0);
    issue(0, 1'b1, 32'h00, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
    issue(0, 1'b0, 32'h00, 32'h0, 4'b0000, 32'h0000_0037, 1'b0);

    // Backpressure: load word 1, then present a competing store that must be ignored.
    resp_ready = 1'b0;
    sb0.push_back({1'b0, 32'hAA22_CC44});
    req_we   = 1'b0;
    req_addr = 32'h04;
    req_be   = 4'b1111;
    rv[0]    = 1'b1;
    @(posedge clk); #1;
    req_we    = 1'b1;
    req_addr  = 32'h00;
    req_wdata = 32'hFFFF_FFFF;
    n = 0;
    while (!vv[0] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      chk("bp_resp_valid", {31'b0, vv[0]}, 32'd1);
      chk("bp_rdata", rd0, 32'hAA22_CC44);
      chk("bp_req_ready", {31'b0, rr[0]}, 32'd0);
      @(posedge clk); #1;
    end
    rv[0]      = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {31'b0, vv[0]}, 32'd0);
    chk("bp_release_ready", {31'b0, rr[0]}, 32'd1);
    chk("bp_release_rdata", rd0, 32'd0);
    issue(0, 1'b0, 32'h00, 32'h0, 4'b1111, 32'h0000_0037, 1'b0);

    // Reset during WAIT aborts the store to word 2.
    issue(0, 1'b1, 32'h08, 32'h1234_5678, 4'b1111, 32'h0, 1'b0);
    req_we    = 1'b1;
    req_addr  = 32'h08;
    req_wdata = 32'hDEAD_BEEF;
    req_be    = 4'b1111;
    rv[0]     = 1'b1;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    rst   = 1'b0;
    #1;
    chk("abort_req_ready", {31'b0, rr[0]}, 32'd1);
    chk("abort_resp_valid", {31'b0, vv[0]}, 32'd0);
    chk("abort_rdata", rd0, 32'd0);
    chk("abort_err", {31'b0, ee[0]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    issue(0, 1'b0, 32'h08, 32'h0, 4'b1111, 32'h1234_5678, 1'b0);

    issue(1, 1'b1, 32'h0C, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0);
    issue(1, 1'b0, 32'h0C, 32'h0, 4'b1111, 32'hCAFE_F00D, 1'b0);
    issue(1, 1'b0, 32'h101, 32'h0, 4'b1111, 32'h0, 1'b1);

    chk("scoreboard_drained", 32'(sb0.size() + sb1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
